// File: rtl/axi_reg_responder.sv
// axi_reg_responder
//   Responder end of the reduced AXI subset (18-bit address, 16-bit data,
//   no strobes, no response codes). Serves a local word RAM plus two
//   read-only status registers: ID at 18'h3FFFF and a 16-bit write-commit
//   counter at 18'h3FFFE. Read and write paths run independently.
//
// Ports
//   clk, axi_resetn                    clock, async active-low reset
//   axi_ar_addr/valid/ready            read address channel
//   axi_r_data/valid/ready             read data channel
//   axi_aw_addr/valid/ready            write address channel
//   axi_w_data/valid/ready             write data channel
//   axi_b_valid/ready                  write response channel
module axi_reg_responder #(
   parameter int          DEPTH_BITS = 8,
   parameter logic [15:0] ID_VALUE   = 16'hD0B6
) (
   input  logic        clk,
   input  logic        axi_resetn,
   input  logic [17:0] axi_ar_addr,
   input  logic        axi_ar_valid,
   output logic        axi_ar_ready,
   output logic [15:0] axi_r_data,
   output logic        axi_r_valid,
   input  logic        axi_r_ready,
   input  logic [17:0] axi_aw_addr,
   input  logic        axi_aw_valid,
   output logic        axi_aw_ready,
   input  logic [15:0] axi_w_data,
   input  logic        axi_w_valid,
   output logic        axi_w_ready,
   output logic        axi_b_valid,
   input  logic        axi_b_ready
);

   localparam int DEPTH = 1 << DEPTH_BITS;

   localparam logic R_IDLE    = 1'b0;
   localparam logic R_RESP    = 1'b1;
   localparam logic W_COLLECT = 1'b0;
   localparam logic W_RESP    = 1'b1;

   logic [15:0] mem [DEPTH];

   // read path
   logic        r_state_q, r_state_d;
   logic        ar_ready_q, ar_ready_d;
   logic        r_valid_q, r_valid_d;
   logic [15:0] r_data_q, r_data_d;
   logic [15:0] rd_val;

   // write path
   logic        w_state_q, w_state_d;
   logic        aw_ready_q, aw_ready_d;
   logic        w_ready_q, w_ready_d;
   logic        aw_got_q, aw_got_d;
   logic        w_got_q, w_got_d;
   logic [17:0] aw_addr_q, aw_addr_d;
   logic [15:0] w_data_q, w_data_d;
   logic        b_valid_q, b_valid_d;
   logic [15:0] wr_cnt_q, wr_cnt_d;

   logic        aw_hs, w_hs, aw_have, w_have;
   logic [17:0] wr_addr;
   logic [15:0] wr_data;
   logic        mem_we;

   // Read decode uses current (pre-commit) RAM and counter contents, so a
   // write or count increment on the same edge is not visible.
   always_comb begin
      rd_val = '0;
      if (axi_ar_addr[17:DEPTH_BITS] == '0)
         rd_val = mem[axi_ar_addr[DEPTH_BITS-1:0]];
      else if (axi_ar_addr == 18'h3FFFF)
         rd_val = ID_VALUE;
      else if (axi_ar_addr == 18'h3FFFE)
         rd_val = wr_cnt_q;
   end

   always_comb begin
      r_state_d  = r_state_q;
      ar_ready_d = ar_ready_q;
      r_valid_d  = r_valid_q;
      r_data_d   = r_data_q;
      case (r_state_q)
         R_IDLE: begin
            ar_ready_d = 1'b1;
            if (axi_ar_valid && ar_ready_q) begin
               r_data_d   = rd_val;
               r_valid_d  = 1'b1;
               ar_ready_d = 1'b0;
               r_state_d  = R_RESP;
            end
         end
         default: begin
            if (axi_r_ready) begin
               r_valid_d  = 1'b0;
               ar_ready_d = 1'b1;
               r_state_d  = R_IDLE;
            end
         end
      endcase
   end

   // A channel counts as "have" if it was captured earlier or handshakes
   // now; commit fires on the edge where both are present, taking the
   // live bus value for whichever channel completes on this edge.
   assign aw_hs   = axi_aw_valid & aw_ready_q;
   assign w_hs    = axi_w_valid & w_ready_q;
   assign aw_have = aw_got_q | aw_hs;
   assign w_have  = w_got_q | w_hs;
   assign wr_addr = aw_hs ? axi_aw_addr : aw_addr_q;
   assign wr_data = w_hs ? axi_w_data : w_data_q;

   always_comb begin
      w_state_d  = w_state_q;
      aw_ready_d = aw_ready_q;
      w_ready_d  = w_ready_q;
      aw_got_d   = aw_got_q;
      w_got_d    = w_got_q;
      aw_addr_d  = aw_addr_q;
      w_data_d   = w_data_q;
      b_valid_d  = b_valid_q;
      wr_cnt_d   = wr_cnt_q;
      mem_we     = 1'b0;
      case (w_state_q)
         W_COLLECT: begin
            if (aw_hs) begin
               aw_addr_d = axi_aw_addr;
               aw_got_d  = 1'b1;
            end
            if (w_hs) begin
               w_data_d = axi_w_data;
               w_got_d  = 1'b1;
            end
            if (aw_have && w_have) begin
               mem_we     = (wr_addr[17:DEPTH_BITS] == '0);
               wr_cnt_d   = wr_cnt_q + 16'd1;
               b_valid_d  = 1'b1;
               aw_got_d   = 1'b0;
               w_got_d    = 1'b0;
               aw_ready_d = 1'b0;
               w_ready_d  = 1'b0;
               w_state_d  = W_RESP;
            end else begin
               aw_ready_d = ~aw_have;
               w_ready_d  = ~w_have;
            end
         end
         default: begin
            if (axi_b_ready) begin
               b_valid_d  = 1'b0;
               aw_ready_d = 1'b1;
               w_ready_d  = 1'b1;
               w_state_d  = W_COLLECT;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_state_q  <= R_IDLE;
         ar_ready_q <= 1'b0;
         r_valid_q  <= 1'b0;
         r_data_q   <= '0;
         w_state_q  <= W_COLLECT;
         aw_ready_q <= 1'b0;
         w_ready_q  <= 1'b0;
         aw_got_q   <= 1'b0;
         w_got_q    <= 1'b0;
         aw_addr_q  <= '0;
         w_data_q   <= '0;
         b_valid_q  <= 1'b0;
         wr_cnt_q   <= '0;
      end else begin
         r_state_q  <= r_state_d;
         ar_ready_q <= ar_ready_d;
         r_valid_q  <= r_valid_d;
         r_data_q   <= r_data_d;
         w_state_q  <= w_state_d;
         aw_ready_q <= aw_ready_d;
         w_ready_q  <= w_ready_d;
         aw_got_q   <= aw_got_d;
         w_got_q    <= w_got_d;
         aw_addr_q  <= aw_addr_d;
         w_data_q   <= w_data_d;
         b_valid_q  <= b_valid_d;
         wr_cnt_q   <= wr_cnt_d;
      end
   end

   // RAM contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[wr_addr[DEPTH_BITS-1:0]] <= wr_data;
   end

   assign axi_ar_ready = ar_ready_q;
   assign axi_r_valid  = r_valid_q;
   assign axi_r_data   = r_data_q;
   assign axi_aw_ready = aw_ready_q;
   assign axi_w_ready  = w_ready_q;
   assign axi_b_valid  = b_valid_q;

endmodule

// File: tb/tb_axi_reg_responder.sv
// Directed bench for axi_reg_responder: stimulus tasks push expected R data
// and B timing into queues; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_axi_reg_responder;

   logic        clk = 1'b0;
   logic        axi_resetn;
   logic [17:0] axi_ar_addr;
   logic        axi_ar_valid;
   logic        axi_ar_ready;
   logic [15:0] axi_r_data;
   logic        axi_r_valid;
   logic        axi_r_ready;
   logic [17:0] axi_aw_addr;
   logic        axi_aw_valid;
   logic        axi_aw_ready;
   logic [15:0] axi_w_data;
   logic        axi_w_valid;
   logic        axi_w_ready;
   logic        axi_b_valid;
   logic        axi_b_ready;

   axi_reg_responder #(.DEPTH_BITS(8), .ID_VALUE(16'hD0B6)) dut (
      .clk(clk), .axi_resetn(axi_resetn),
      .axi_ar_addr(axi_ar_addr), .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
      .axi_r_data(axi_r_data), .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
      .axi_aw_addr(axi_aw_addr), .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
      .axi_w_data(axi_w_data), .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
      .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } r_exp_t;

   r_exp_t r_q[$];
   int     b_q[$];
   int     n_cmp = 0;
   int     n_err = 0;
   int     cnt_m = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: compare each new R/B presentation, then check it is held
   logic        r_seen = 1'b0, b_seen = 1'b0;
   logic [15:0] r_hold = '0;
   always @(negedge clk) begin
      if (!axi_resetn) begin
         r_seen = 1'b0;
         b_seen = 1'b0;
      end else begin
         if (axi_r_valid) begin
            if (!r_seen) begin
               if (r_q.size() == 0) chk("r_unexpected", axi_r_valid, 1'b0);
               else begin
                  r_exp_t e;
                  e = r_q.pop_front();
                  chk("r_data", axi_r_data, e.data);
                  chk("r_latency", cyc, e.cyc);
               end
               r_hold = axi_r_data;
            end else chk("r_stable", axi_r_data, r_hold);
            r_seen = !axi_r_ready;
         end else begin
            if (r_seen) chk("r_drop", axi_r_valid, 1'b1);
            r_seen = 1'b0;
         end
         if (axi_b_valid) begin
            if (!b_seen) begin
               if (b_q.size() == 0) chk("b_unexpected", axi_b_valid, 1'b0);
               else chk("b_latency", cyc, b_q.pop_front());
            end
            b_seen = !axi_b_ready;
         end else begin
            if (b_seen) chk("b_drop", axi_b_valid, 1'b1);
            b_seen = 1'b0;
         end
      end
   end

   // called at posedge+1; returns at posedge+1 after the AR handshake edge
   task automatic read_txn(input logic [17:0] a, input logic [15:0] exp);
      int n = 0;
      r_exp_t e;
      axi_ar_addr  = a;
      axi_ar_valid = 1'b1;
      @(negedge clk);
      while (!axi_ar_ready && n < 100) begin n++; @(negedge clk); end
      if (n >= 100) chk("ar_timeout", axi_ar_ready, 1'b1);
      e.data = exp;
      e.cyc  = cyc + 1;
      r_q.push_back(e);
      @(posedge clk); #1;
      axi_ar_valid = 1'b0;
   endtask

   task automatic write_txn(input logic [17:0] a, input logic [15:0] d,
                            input int aw_dly, input int w_dly);
      int aw_c = 0, w_c = 0;
      fork
         begin
            int n = 0;
            repeat (aw_dly) begin @(posedge clk); #1; end
            axi_aw_addr  = a;
            axi_aw_valid = 1'b1;
            @(negedge clk);
            while (!axi_aw_ready && n < 100) begin n++; @(negedge clk); end
            if (n >= 100) chk("aw_timeout", axi_aw_ready, 1'b1);
            aw_c = cyc + 1;
            @(posedge clk); #1;
            axi_aw_valid = 1'b0;
         end
         begin
            int n = 0;
            repeat (w_dly) begin @(posedge clk); #1; end
            axi_w_data  = d;
            axi_w_valid = 1'b1;
            @(negedge clk);
            while (!axi_w_ready && n < 100) begin n++; @(negedge clk); end
            if (n >= 100) chk("w_timeout", axi_w_ready, 1'b1);
            w_c = cyc + 1;
            @(posedge clk); #1;
            axi_w_valid = 1'b0;
         end
      join
      b_q.push_back((aw_c > w_c) ? aw_c : w_c);
      cnt_m++;
   endtask

   task automatic drain();
      int n = 0;
      while (n < 60 && (r_q.size() != 0 || b_q.size() != 0 || axi_r_valid || axi_b_valid)) begin
         n++;
         @(negedge clk);
      end
      @(negedge clk);
      chk("drain_pending", r_q.size() + b_q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      axi_resetn = 1'b0;
      axi_ar_addr = '0; axi_ar_valid = 1'b0; axi_r_ready = 1'b1;
      axi_aw_addr = '0; axi_aw_valid = 1'b0;
      axi_w_data = '0;  axi_w_valid = 1'b0;  axi_b_ready = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ar_ready", axi_ar_ready, 1'b0);
      chk("rst_aw_ready", axi_aw_ready, 1'b0);
      chk("rst_w_ready", axi_w_ready, 1'b0);
      chk("rst_r_valid", axi_r_valid, 1'b0);
      chk("rst_b_valid", axi_b_valid, 1'b0);
      chk("rst_r_data", axi_r_data, 16'h0000);
      axi_resetn = 1'b1;
      @(posedge clk); #1;
      chk("rel_ar_ready", axi_ar_ready, 1'b1);
      chk("rel_aw_ready", axi_aw_ready, 1'b1);
      chk("rel_w_ready", axi_w_ready, 1'b1);

      read_txn(18'h3FFFF, 16'hD0B6);
      drain();
      read_txn(18'h3FFFE, 16'h0000);
      drain();

      // AW first, W three cycles later
      write_txn(18'h00012, 16'hBEEF, 0, 3);
      drain();
      read_txn(18'h00012, 16'hBEEF);
      drain();
      read_txn(18'h3FFFE, 16'h0001);
      drain();

      // W before AW, then both together with b_ready held low
      write_txn(18'h000FF, 16'h1234, 3, 0);
      drain();
      axi_b_ready = 1'b0;
      write_txn(18'h000FF, 16'h1234, 0, 0);
      repeat (5) begin
         @(negedge clk);
         chk("b_hold_valid", axi_b_valid, 1'b1);
         chk("b_hold_aw_ready", axi_aw_ready, 1'b0);
      end
      @(posedge clk); #1;
      axi_b_ready = 1'b1;
      drain();
      read_txn(18'h000FF, 16'h1234);
      drain();

      // discarded writes still count
      write_txn(18'h3FFFF, 16'hAAAA, 0, 0);
      drain();
      write_txn(18'h01000, 16'hAAAA, 1, 0);
      drain();
      read_txn(18'h3FFFF, 16'hD0B6);
      drain();
      read_txn(18'h01000, 16'h0000);
      drain();
      read_txn(18'h3FFFE, 16'h0005);
      drain();

      // same-edge write and read of address 5
      write_txn(18'h00005, 16'h0001, 0, 0);
      drain();
      fork
         write_txn(18'h00005, 16'h5555, 0, 0);
         read_txn(18'h00005, 16'h0001);
      join
      drain();
      read_txn(18'h00005, 16'h5555);
      drain();
      read_txn(18'h3FFFE, cnt_m[15:0]);
      drain();

      // r_ready held low: data stays, no new AR accepted
      axi_r_ready = 1'b0;
      read_txn(18'h00012, 16'hBEEF);
      repeat (4) begin
         @(negedge clk);
         chk("r_hold_ar_ready", axi_ar_ready, 1'b0);
         chk("r_hold_valid", axi_r_valid, 1'b1);
      end
      @(posedge clk); #1;
      axi_r_ready = 1'b1;
      drain();

      // reset while in W_RESP
      axi_b_ready = 1'b0;
      write_txn(18'h00020, 16'h7777, 0, 0);
      @(posedge clk); #3;
      axi_resetn = 1'b0;
      #1;
      chk("wrst_b_valid", axi_b_valid, 1'b0);
      chk("wrst_aw_ready", axi_aw_ready, 1'b0);
      b_q.delete();
      axi_b_ready = 1'b1;
      @(negedge clk); #1;
      axi_resetn = 1'b1;
      @(posedge clk); #1;
      chk("wrst_rel_aw_ready", axi_aw_ready, 1'b1);
      repeat (6) @(posedge clk);
      #1;
      cnt_m = 0;
      read_txn(18'h3FFFE, 16'h0000);
      drain();

      // reset while in R_RESP
      axi_r_ready = 1'b0;
      read_txn(18'h3FFFF, 16'hD0B6);
      @(posedge clk); #3;
      axi_resetn = 1'b0;
      #1;
      chk("rrst_r_valid", axi_r_valid, 1'b0);
      chk("rrst_r_data", axi_r_data, 16'h0000);
      chk("rrst_ar_ready", axi_ar_ready, 1'b0);
      r_q.delete();
      axi_r_ready = 1'b1;
      @(negedge clk); #1;
      axi_resetn = 1'b1;
      @(posedge clk); #1;
      chk("rrst_rel_ar_ready", axi_ar_ready, 1'b1);
      repeat (6) @(posedge clk);
      #1;
      chk("rrst_no_stale_r", axi_r_valid, 1'b0);
      chk("rrst_no_stale_b", axi_b_valid, 1'b0);
      read_txn(18'h00020, 16'h7777);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi_reg_responder.md
Name: axi_reg_responder

Overview:
- Responder end of the team's reduced AXI subset: 18-bit address, 16-bit data, no strobes, no response codes.
- Accepts read and write transactions from the UART debug initiator or any other master, and serves them from a local word RAM plus two read-only status registers.
- Read and write paths are independent and may be active in the same cycle.

Parameters:
- DEPTH_BITS, 8, log2 of RAM depth in 16-bit words; RAM occupies addresses 0 .. 2^DEPTH_BITS-1.
- ID_VALUE, 16'hD0B6, constant returned by the ID register.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- axi_resetn  in  1  asynchronous, active-low reset.
- axi_ar_addr  in  18  read address.
- axi_ar_valid  in  1  read address valid.
- axi_ar_ready  out  1  read address ready.
- axi_r_data  out  16  read data.
- axi_r_valid  out  1  read data valid.
- axi_r_ready  in  1  read data ready.
- axi_aw_addr  in  18  write address.
- axi_aw_valid  in  1  write address valid.
- axi_aw_ready  out  1  write address ready.
- axi_w_data  in  16  write data.
- axi_w_valid  in  1  write data valid.
- axi_w_ready  out  1  write data ready.
- axi_b_valid  out  1  write response valid.
- axi_b_ready  in  1  write response ready.

Behaviour:
- Reset (asynchronous assert on axi_resetn low):
  - All ready and valid outputs = 0; axi_r_data = 0; write counter = 0; both FSMs go to IDLE. RAM contents are not reset.
  - On the first rising edge with axi_resetn high, ar_ready, aw_ready and w_ready go to 1.
  - Reset asserted mid-transaction drops the transaction; no B or R is issued for it.
- Address map:
  - addr < 2^DEPTH_BITS: RAM word, read/write.
  - 18'h3FFFF: ID register, reads ID_VALUE; writes are discarded.
  - 18'h3FFFE: write counter, 16 bits, read-only; writes are discarded.
  - Any other address: reads return 16'h0000; writes are discarded.
- Read FSM, states R_IDLE and R_RESP:
  - R_IDLE: ar_ready = 1. On ar_valid & ar_ready: decode address, register axi_r_data, set r_valid = 1 and ar_ready = 0, go to R_RESP. AR-to-R latency is exactly 1 cycle.
  - R_RESP: hold r_data and r_valid stable until r_ready. On r_valid & r_ready: r_valid = 0, ar_ready = 1, go to R_IDLE. The next AR can therefore be accepted no earlier than 1 cycle after the R handshake.
  - Read data is sampled at the AR handshake edge. A write committing on that same edge is not visible; the read returns the old value.
- Write FSM, states W_COLLECT and W_RESP:
  - W_COLLECT: aw_ready and w_ready are independent.
    - AW handshake captures the address and clears aw_ready.
    - W handshake captures the data and clears w_ready.
    - AW and W may arrive in either order or in the same cycle.
  - Commit happens on the edge where the later of the two handshakes completes, or where both complete together. On that edge:
    - RAM is written if the address is in range.
    - The write counter increments for every commit, including discarded ones, and wraps 16'hFFFF -> 16'h0000.
    - b_valid is set to 1; go to W_RESP.
  - W_RESP: aw_ready = w_ready = 0; b_valid is held until b_ready. On b_valid & b_ready: b_valid = 0, aw_ready = w_ready = 1, go to W_COLLECT.
  - Minimum commit latency is 1 cycle after the handshake (b_valid is visible the cycle after it). A master that asserts b_ready early, or only after both channels complete, is supported.
- Valid/ready rules: valid outputs never drop without a handshake. Outputs are registered; there are no combinational input-to-output paths.
- Simultaneous events:
  - Read and write to the same RAM address on the same edge: the write lands and the read returns the old data.
  - A read of 18'h3FFFE on a commit edge returns the pre-increment count.

Test Plan:
- Reset release: readies 0 during reset and 1 on the first edge after release. Read 18'h3FFFF -> r_data 16'hD0B6 with r_valid exactly 1 cycle after the AR handshake. Read 18'h3FFFE -> 16'h0000.
- Write addr 18'h00012 with data 16'hBEEF, AW first then W 3 cycles later -> b_valid 1 cycle after the W handshake. Read 18'h00012 -> 16'hBEEF. Counter read -> 16'h0001.
- W before AW, and AW+W in the same cycle, to addr 18'h000FF with data 16'h1234 -> one commit each, b_valid held while b_ready is low for 5 cycles. Read back 16'h1234.
- Write 16'hAAAA to 18'h3FFFF and to 18'h01000 (out of range, DEPTH_BITS = 8) -> B returned, ID still reads 16'hD0B6, 18'h01000 reads 16'h0000, counter increments by 2.
- Preload addr 5 with 16'h0001. Issue write 16'h5555 to addr 5 and AR for addr 5 so that both land on the same edge -> read returns 16'h0001, a later read returns 16'h5555. Then hold r_ready low for 4 cycles -> r_data stable and ar_ready 0.
- Pull axi_resetn low while in W_RESP and in R_RESP -> b_valid and r_valid drop immediately, and no stale response appears after release.
